// File: rtl/ff_pkg.sv
// ff_pkg
// Shared definitions for the universal flip-flop bank: the 2-bit mode
// encoding used on the bank's mode select and by every per-bit cell.
//   MODE_D  (00) : q <= a
//   MODE_T  (01) : q <= q ^ a
//   MODE_SR (10) : a = S, b = R, S=R=1 holds and flags illegal
//   MODE_JK (11) : a = J, b = K, J=K=1 toggles
package ff_pkg;

  typedef enum logic [1:0] {
    MODE_D  = 2'b00,
    MODE_T  = 2'b01,
    MODE_SR = 2'b10,
    MODE_JK = 2'b11
  } mode_t;

endpackage

// File: rtl/universal_ff_cell.sv
// universal_ff_cell
// Purely combinational next-state logic for one flip-flop bit of the bank.
// It holds no state; the bank owns the register and decides whether the
// value computed here is used (ld/en priority lives at bank level).
// Ports:
//   mode    in  2  mode select (see ff_pkg)
//   q       in  1  current registered value of this bit
//   a       in  1  D data / T toggle / S / J
//   b       in  1  R / K (unused in D and T modes)
//   next_q  out 1  value this bit takes if the bank applies a mode update
//   ill     out 1  this bit sees S=R=1 in SR mode
module universal_ff_cell
  import ff_pkg::*;
(
  input  logic [1:0] mode,
  input  logic       q,
  input  logic       a,
  input  logic       b,
  output logic       next_q,
  output logic       ill
);

  // S=R=1 is a defined hold-plus-flag case rather than an X source, so the
  // SR and JK tables differ only in their 11 row.
  always_comb begin
    next_q = q;
    ill    = 1'b0;
    case (mode_t'(mode))
      MODE_D:  next_q = a;
      MODE_T:  next_q = q ^ a;
      MODE_SR: begin
        case ({a, b})
          2'b01:   next_q = 1'b0;
          2'b10:   next_q = 1'b1;
          2'b11:   ill    = 1'b1;
          default: next_q = q;
        endcase
      end
      MODE_JK: begin
        case ({a, b})
          2'b01:   next_q = 1'b0;
          2'b10:   next_q = 1'b1;
          2'b11:   next_q = ~q;
          default: next_q = q;
        endcase
      end
      default: next_q = q;
    endcase
  end

endmodule

// File: rtl/universal_ff_bank.sv
// universal_ff_bank
// WIDTH-bit bank of mode-selectable flip-flops (D/T/SR/JK) with a shared
// clock, asynchronous reset, clock enable, synchronous parallel load and
// accounting of illegal SR (S=R=1) events.
// Ports:
//   c              in  1      clock, rising edge
//   rs             in  1      asynchronous active-high reset
//   en             in  1      enable for mode-driven updates
//   mode           in  2      00=D 01=T 10=SR 11=JK
//   a              in  WIDTH  D / T / S / J per bit
//   b              in  WIDTH  R / K per bit
//   ld             in  1      synchronous parallel load (beats en)
//   ld_val         in  WIDTH  value loaded when ld=1
//   clr_err        in  1      synchronous clear of sticky flag and counter
//   q              out WIDTH  registered state
//   qb             out WIDTH  combinational ~q
//   illegal        out WIDTH  per-bit S=R=1 seen on the last enabled edge
//   illegal_sticky out 1      any illegal event since last clear/reset
//   err_cnt        out CNT_W  saturating count of edges with an illegal bit
module universal_ff_bank
  import ff_pkg::*;
#(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0,
  parameter int                 CNT_W     = 4
) (
  input  logic             c,
  input  logic             rs,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic [WIDTH-1:0] illegal,
  output logic             illegal_sticky,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] cell_q;
  logic [WIDTH-1:0] cell_ill;
  logic [WIDTH-1:0] next_q;
  logic [WIDTH-1:0] next_ill;
  logic             any_ill;
  logic             next_sticky;
  logic [CNT_W-1:0] next_cnt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    universal_ff_cell u_cell (
      .mode   (mode),
      .q      (q[i]),
      .a      (a[i]),
      .b      (b[i]),
      .next_q (cell_q[i]),
      .ill    (cell_ill[i])
    );
  end

  // Load beats enable beats hold. Only an enabled mode update may raise
  // illegal bits, so a load never feeds the error accounting.
  always_comb begin
    next_q   = q;
    next_ill = '0;
    if (ld) begin
      next_q = ld_val;
    end else if (en) begin
      next_q   = cell_q;
      next_ill = cell_ill;
    end
  end

  assign any_ill = |next_ill;

  // A new illegal event on the same edge as clr_err wins: the clear is
  // applied first and the event then counts as the first one.
  always_comb begin
    next_sticky = illegal_sticky;
    next_cnt    = err_cnt;
    if (any_ill) begin
      next_sticky = 1'b1;
      if (clr_err) begin
        next_cnt = CNT_ONE;
      end else if (err_cnt != CNT_MAX) begin
        next_cnt = err_cnt + CNT_ONE;
      end
    end else if (clr_err) begin
      next_sticky = 1'b0;
      next_cnt    = '0;
    end
  end

  always_ff @(posedge c or posedge rs) begin
    if (rs) begin
      q              <= RESET_VAL;
      illegal        <= '0;
      illegal_sticky <= 1'b0;
      err_cnt        <= '0;
    end else begin
      q              <= next_q;
      illegal        <= next_ill;
      illegal_sticky <= next_sticky;
      err_cnt        <= next_cnt;
    end
  end

  assign qb = ~q;

endmodule

// File: tb/tb_universal_ff_bank.sv
// tb_universal_ff_bank
// Self-checking bench for universal_ff_bank (WIDTH=8, CNT_W=4): directed
// vector table, hand-written multi-cycle sequences and randomized traffic
// checked against a behavioural model.
module tb_universal_ff_bank;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic             c;
  logic             rs;
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ld;
  logic [WIDTH-1:0] ld_val;
  logic             clr_err;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb;
  logic [WIDTH-1:0] illegal;
  logic             illegal_sticky;
  logic [CNT_W-1:0] err_cnt;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] m_ill;
  logic             m_sticky;
  int               m_cnt;

  typedef struct {
    logic             ld;
    logic [WIDTH-1:0] ld_val;
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             clr;
    logic [WIDTH-1:0] eq;
    logic [WIDTH-1:0] eill;
    logic             est;
    int               ecnt;
  } vec_t;

  vec_t vecs[12];

  universal_ff_bank #(.WIDTH(WIDTH), .RESET_VAL('0), .CNT_W(CNT_W)) dut (
    .c              (c),
    .rs             (rs),
    .en             (en),
    .mode           (mode),
    .a              (a),
    .b              (b),
    .ld             (ld),
    .ld_val         (ld_val),
    .clr_err        (clr_err),
    .q              (q),
    .qb             (qb),
    .illegal        (illegal),
    .illegal_sticky (illegal_sticky),
    .err_cnt        (err_cnt)
  );

  initial c = 1'b0;
  always #5 c = ~c;

  function automatic vec_t mkVec(input logic l, input logic [7:0] lv, input logic e,
                                 input logic [1:0] m, input logic [7:0] va, input logic [7:0] vb,
                                 input logic cl, input logic [7:0] eq, input logic [7:0] eill,
                                 input logic est, input int ecnt);
    vec_t v;
    v.ld = l; v.ld_val = lv; v.en = e; v.mode = m; v.a = va; v.b = vb; v.clr = cl;
    v.eq = eq; v.eill = eill; v.est = est; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic modelReset;
    m_q = '0; m_ill = '0; m_sticky = 1'b0; m_cnt = 0;
  endtask

  // Next state from the mode rules expressed as whole-word bit equations.
  task automatic modelStep;
    logic [WIDTH-1:0] nq;
    logic [WIDTH-1:0] nill;
    nill = '0;
    if (ld) begin
      nq = ld_val;
    end else if (en) begin
      case (mode)
        2'd0:    nq = a;
        2'd1:    nq = m_q ^ a;
        2'd2:    begin nq = (m_q | (a & ~b)) & ~(b & ~a); nill = a & b; end
        default: nq = (a & ~m_q) | (~b & m_q);
      endcase
    end else begin
      nq = m_q;
    end
    if (nill != 0) begin
      m_sticky = 1'b1;
      m_cnt = clr_err ? 1 : ((m_cnt < CNT_SAT) ? m_cnt + 1 : CNT_SAT);
    end else if (clr_err) begin
      m_sticky = 1'b0;
      m_cnt = 0;
    end
    m_q = nq;
    m_ill = nill;
  endtask

  task automatic applyStimulus(input logic l, input logic [7:0] lv, input logic e,
                               input logic [1:0] m, input logic [7:0] va, input logic [7:0] vb,
                               input logic cl);
    @(negedge c);
    ld = l; ld_val = lv; en = e; mode = m; a = va; b = vb; clr_err = cl;
    modelStep();
    @(posedge c);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] eq, input logic [7:0] eill,
                             input logic est, input int ecnt);
    total++;
    if (q !== eq) begin
      bad++; $display("[TB] FAIL %s q: got %h expected %h", name, q, eq);
    end
    total++;
    if (qb !== ~eq) begin
      bad++; $display("[TB] FAIL %s qb: got %h expected %h", name, qb, ~eq);
    end
    total++;
    if (illegal !== eill) begin
      bad++; $display("[TB] FAIL %s illegal: got %h expected %h", name, illegal, eill);
    end
    total++;
    if (illegal_sticky !== est) begin
      bad++; $display("[TB] FAIL %s sticky: got %b expected %b", name, illegal_sticky, est);
    end
    total++;
    if (err_cnt !== CNT_W'(ecnt)) begin
      bad++; $display("[TB] FAIL %s err_cnt: got %0d expected %0d", name, err_cnt, ecnt);
    end
  endtask

  initial begin
    rs = 1'b1; en = 1'b0; mode = 2'd0; a = '0; b = '0;
    ld = 1'b0; ld_val = '0; clr_err = 1'b0;
    modelReset();

    //            ld lval  en mode a      b      clr  eq     eill   st cnt
    vecs[0]  = mkVec(0, 8'h00, 1, 2'd0, 8'h3C, 8'h00, 0, 8'h3C, 8'h00, 0, 0);
    vecs[1]  = mkVec(0, 8'h00, 1, 2'd1, 8'hFF, 8'h00, 0, 8'hC3, 8'h00, 0, 0);
    vecs[2]  = mkVec(0, 8'h00, 1, 2'd1, 8'h00, 8'h00, 0, 8'hC3, 8'h00, 0, 0);
    vecs[3]  = mkVec(1, 8'h00, 0, 2'd0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0);
    vecs[4]  = mkVec(0, 8'h00, 1, 2'd2, 8'hF0, 8'h0F, 0, 8'hF0, 8'h00, 0, 0);
    vecs[5]  = mkVec(0, 8'h00, 1, 2'd2, 8'hFF, 8'h0F, 0, 8'hF0, 8'h0F, 1, 1);
    vecs[6]  = mkVec(0, 8'h00, 0, 2'd2, 8'hFF, 8'hFF, 0, 8'hF0, 8'h00, 1, 1);
    vecs[7]  = mkVec(1, 8'hAA, 0, 2'd3, 8'h00, 8'h00, 0, 8'hAA, 8'h00, 1, 1);
    vecs[8]  = mkVec(0, 8'h00, 1, 2'd3, 8'hFF, 8'hFF, 0, 8'h55, 8'h00, 1, 1);
    vecs[9]  = mkVec(0, 8'h00, 1, 2'd3, 8'h0F, 8'hF0, 0, 8'h0F, 8'h00, 1, 1);
    vecs[10] = mkVec(1, 8'h5A, 1, 2'd2, 8'hFF, 8'hFF, 0, 8'h5A, 8'h00, 1, 1);
    vecs[11] = mkVec(0, 8'h00, 0, 2'd0, 8'h00, 8'h00, 1, 8'h5A, 8'h00, 0, 0);

    repeat (2) @(posedge c);
    #1;
    checkOutput("reset_state", 8'h00, 8'h00, 1'b0, 0);
    @(negedge c);
    rs = 1'b0;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].ld, vecs[i].ld_val, vecs[i].en, vecs[i].mode,
                    vecs[i].a, vecs[i].b, vecs[i].clr);
      checkOutput($sformatf("vec%0d", i), vecs[i].eq, vecs[i].eill, vecs[i].est, vecs[i].ecnt);
    end

    // Counter saturation, then clear racing an illegal edge, then plain clear.
    for (int i = 0; i < 20; i++)
      applyStimulus(0, 8'h00, 1, 2'd2, 8'hFF, 8'hFF, 0);
    checkOutput("saturate", 8'h5A, 8'hFF, 1'b1, 15);
    applyStimulus(0, 8'h00, 1, 2'd2, 8'hFF, 8'hFF, 1);
    checkOutput("clr_with_ill", 8'h5A, 8'hFF, 1'b1, 1);
    applyStimulus(0, 8'h00, 0, 2'd2, 8'h00, 8'h00, 1);
    checkOutput("clr_alone", 8'h5A, 8'h00, 1'b0, 0);

    // Reset mid-operation: must take effect between edges.
    applyStimulus(0, 8'h00, 1, 2'd2, 8'hFF, 8'hFF, 0);
    applyStimulus(1, 8'hA5, 0, 2'd0, 8'h00, 8'h00, 0);
    checkOutput("pre_reset", 8'hA5, 8'h00, 1'b1, 1);
    @(negedge c);
    ld = 1'b0; en = 1'b1; mode = 2'd0; a = 8'hFF; b = 8'h00; clr_err = 1'b0;
    #2;
    rs = 1'b1;
    #1;
    checkOutput("async_reset", 8'h00, 8'h00, 1'b0, 0);
    @(posedge c);
    #1;
    checkOutput("reset_held", 8'h00, 8'h00, 1'b0, 0);
    @(negedge c);
    rs = 1'b0;
    modelReset();
    modelStep();
    @(posedge c);
    #1;
    checkOutput("first_after_reset", 8'hFF, 8'h00, 1'b0, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 9) == 0, 8'($urandom), $urandom_range(0, 3) != 0,
                    2'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 7) == 0);
      checkOutput($sformatf("rand%0d", i), m_q, m_ill, m_sticky, m_cnt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
